exec_mem_unit: RTL and testbench
================================

Name: exec_mem_unit

Overview:
- Execute/memory datapath slice of the 5-stage RV32I pipeline.
- Combines three parts:
  - ALU-control decoder: alu_op/funct3/op5/funct7_5 to 3-bit alu_control.
  - 32-bit combinational ALU with zero flag, driving the branch decision.
  - Word-addressed data memory: synchronous write, combinational read, asynchronous clear.
- ALU path and memory path are independent. The pipeline registers ALU results before they address memory.

Parameters:
- XLEN, 32, datapath width of ALU operands, result, memory address and data.
- MEM_WORDS, 64, data memory depth in 32-bit words (power of two).

Ports:
- clk  input  1  clock; memory writes occur on the rising edge.
- reset  input  1  asynchronous, active-high; clears all memory words.
- alu_op  input  2  class from main decoder: 00 load/store/jal, 01 branch, 10 R/I-type ALU, 11 reserved.
- funct3  input  3  instr[14:12].
- op5  input  1  instr[5]; 1 = R-type, 0 = I-type.
- funct7_5  input  1  instr[30].
- src_a  input  XLEN  ALU operand A.
- src_b  input  XLEN  ALU operand B.
- alu_control  output  3  decoded ALU operation (combinational).
- alu_result  output  XLEN  ALU result (combinational).
- zero  output  1  1 when alu_result == 0.
- mem_we  input  1  memory write enable.
- mem_adr  input  XLEN  byte address.
- mem_din  input  XLEN  write data.
- mem_dout  output  XLEN  read data (combinational).

Behaviour:
- Decoder (purely combinational):
  - alu_op 00 -> 000 (add).
  - alu_op 01 -> 001 (sub).
  - alu_op 11 -> 000.
  - alu_op 10, by funct3:
    - 000: 001 if op5 & funct7_5, else 000. addi with funct7_5=1 is still add.
    - 010 -> 101 (slt).
    - 110 -> 011 (or).
    - 111 -> 010 (and).
    - any other funct3 -> 000.
- ALU (purely combinational, no internal state):
  - 000: a+b, modulo 2^XLEN, carry discarded.
  - 001: a-b, two's complement, wraps.
  - 010: a&b.
  - 011: a|b.
  - 101: 1 if $signed(a) < $signed(b), else 0; result zero-extended.
  - 100, 110, 111: result 0.
  - zero tracks alu_result for every code, including unused codes (zero=1).
- Memory storage and addressing:
  - MEM_WORDS x XLEN storage.
  - Word index = mem_adr[log2(MEM_WORDS)+1:2].
  - Bits [1:0] ignored (no misaligned faults).
  - Upper address bits ignored, so addresses wrap modulo MEM_WORDS*4.
- Memory read: mem_dout = word[index], combinational.
  - Same-cycle write is not visible until after the clock edge.
- Memory write: on posedge clk with mem_we=1 and reset=0, word[index] <= mem_din.
  - Full-word writes only.
- Memory reset: reset asserted at any time clears every word to 0 immediately, regardless of clk.
  - While reset is high, writes are blocked and mem_dout=0.
  - Reset during a write: the write is dropped.
- Output values under reset:
  - alu_control, alu_result and zero remain combinational functions of their inputs; reset does not affect them.
  - e.g. src_a=src_b=0, alu_op=00 gives alu_result=0, zero=1.
- X/Z handling: X/Z on alu_op decodes as 000.

Test Plan:
- Decoder sweep:
  - alu_op=10, funct3=000, op5=1, funct7_5=1 -> 001.
  - Same with op5=0 -> 000.
  - funct3 010/110/111 -> 101/011/010.
  - alu_op 00/01/11 -> 000/001/000.
- ALU arithmetic:
  - a=0xFFFFFFFF, b=1, add -> 0, zero=1.
  - a=5, b=7, sub -> 0xFFFFFFFE, zero=0.
  - a=0x0F0F, b=0x00FF: and -> 0x000F; or -> 0x0FFF.
- Signed slt:
  - a=0xFFFFFFFF(-1), b=1 -> 1.
  - a=1, b=0xFFFFFFFF -> 0.
  - a=b=0x80000000 -> 0, zero=1.
- Memory write/read:
  - write 0xDEADBEEF at adr 0x60 (word 24) -> mem_dout=0xDEADBEEF at adr 0x60 and 0x63 after the edge.
  - Before the edge -> old value 0.
- Memory wrap and enable:
  - write 0x1234 at adr 0x100 with MEM_WORDS=64 -> readable at adr 0x0.
  - mem_we=0 with a different din -> contents unchanged.
- Asynchronous reset:
  - Write 0xA5A5A5A5 at word 3, then pulse reset between clock edges -> mem_dout at adr 0xC becomes 0 immediately.
  - A write attempted with reset high is ignored.

Source files
------------

// File: rtl/exec_mem_unit.sv
// Execute/memory slice of an RV32I pipeline: ALU-control decoder, combinational ALU
// with zero flag, and a word-addressed data memory with asynchronous clear.
module exec_mem_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            op5,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [2:0]      alu_control,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    input  logic            mem_we,
    input  logic [XLEN-1:0] mem_adr,
    input  logic [XLEN-1:0] mem_din,
    output logic [XLEN-1:0] mem_dout
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ALU-control decode; unknown alu_op falls through to the add default
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            2'b01: alu_control = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    logic less;
    assign less = $signed(src_a) < $signed(src_b);

    // Datapath; unused operation codes produce zero
    always_comb begin
        alu_result = '0;
        case (alu_control)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, less};
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    logic [XLEN-1:0] mem [MEM_WORDS];
    logic [AW-1:0]   idx;
    logic            unused_adr_bits;

    // Byte offset and bits above the array size are dropped, so addresses wrap
    assign idx             = mem_adr[AW+1:2];
    assign unused_adr_bits = ^{mem_adr[XLEN-1:AW+2], mem_adr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[idx] <= mem_din;
        end
    end

    assign mem_dout = reset ? '0 : mem[idx];

endmodule

// File: tb/tb_exec_mem_unit.sv
// Scoreboard bench for exec_mem_unit: stimulus pushes reference-model expectations,
// a monitor pops and compares them against the DUT outputs.
module tb_exec_mem_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        op5;
    logic        funct7_5;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic        zero;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    exec_mem_unit #(.XLEN(32), .MEM_WORDS(64)) dut (
        .clk(clk), .reset(reset),
        .alu_op(alu_op), .funct3(funct3), .op5(op5), .funct7_5(funct7_5),
        .src_a(src_a), .src_b(src_b),
        .alu_control(alu_control), .alu_result(alu_result), .zero(zero),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [95:0] name;
        logic [2:0]  ctl;
        logic [31:0] res;
        logic        z;
        logic [31:0] dout;
    } exp_t;

    exp_t        q[$];
    event        sample_ev;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] mem_model [64];

    // Reference decoder written from the instruction-class rules
    function automatic logic [2:0] ref_ctl(input logic [1:0] op, input logic [2:0] f3,
                                           input logic o5, input logic f7);
        if (op == 2'b01) return 3'b001;
        if (op != 2'b10) return 3'b000;
        if (f3 == 3'b000 && o5 && f7) return 3'b001;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    // Reference ALU using wide integer arithmetic reduced modulo 2^32
    function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        longint unsigned wide;
        logic [31:0]     r;
        r = 32'd0;
        if (c == 3'b000) begin
            wide = longint'(a) + longint'(b);
            r = wide[31:0];
        end else if (c == 3'b001) begin
            wide = (longint'(a) + (64'h1_0000_0000 - longint'(b))) % 64'h1_0000_0000;
            r = wide[31:0];
        end else if (c == 3'b010) begin
            r = a & b;
        end else if (c == 3'b011) begin
            r = a | b;
        end else if (c == 3'b101) begin
            r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        end
        return r;
    endfunction

    function automatic int word_of(input logic [31:0] adr);
        return int'((adr / 4) % 64);
    endfunction

    // Drive one vector, queue its expectation and let the monitor sample it
    task automatic apply(input logic [1:0] op, input logic [2:0] f3, input logic o5,
                         input logic f7, input logic [31:0] a, input logic [31:0] b,
                         input logic we, input logic [31:0] adr, input logic [31:0] din,
                         input logic [95:0] nm);
        exp_t e;
        alu_op = op; funct3 = f3; op5 = o5; funct7_5 = f7;
        src_a = a; src_b = b;
        mem_we = we; mem_adr = adr; mem_din = din;
        e.name = nm;
        e.ctl  = ref_ctl(op, f3, o5, f7);
        e.res  = ref_alu(e.ctl, a, b);
        e.z    = (e.res == 32'd0);
        e.dout = reset ? 32'd0 : mem_model[word_of(adr)];
        q.push_back(e);
        ->sample_ev;
        #2;
    endtask

    // One clock: apply, then commit the write in the model at the edge
    task automatic cycle(input logic [1:0] op, input logic [2:0] f3, input logic o5,
                         input logic f7, input logic [31:0] a, input logic [31:0] b,
                         input logic we, input logic [31:0] adr, input logic [31:0] din,
                         input logic [95:0] nm);
        apply(op, f3, o5, f7, a, b, we, adr, din, nm);
        @(posedge clk);
        if (we && !reset) mem_model[word_of(adr)] = din;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mem_model[i] = 32'd0;
    endtask

    // Monitor: compares every queued expectation against the settled outputs
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            #1;
            if (q.size() == 0) begin
                $display("FAIL scoreboard_empty got no expectation, required one");
                miscompares++;
            end else begin
                e = q.pop_front();
                vectors++;
                if (alu_control !== e.ctl) begin
                    $display("FAIL %0s alu_control got %b required %b", e.name, alu_control, e.ctl);
                    miscompares++;
                end
                if (alu_result !== e.res) begin
                    $display("FAIL %0s alu_result got %h required %h", e.name, alu_result, e.res);
                    miscompares++;
                end
                if (zero !== e.z) begin
                    $display("FAIL %0s zero got %b required %b", e.name, zero, e.z);
                    miscompares++;
                end
                if (mem_dout !== e.dout) begin
                    $display("FAIL %0s mem_dout got %h required %h", e.name, mem_dout, e.dout);
                    miscompares++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] adr;
        clear_model();
        reset = 1'b1;
        #2;
        apply(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'h60, 32'd0, "rst_state");
        apply(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h10, 32'h5555, "rst_wr");
        @(posedge clk);
        #1;
        apply(2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 1'b0, 32'h10, 32'd0, "rst_wr_chk");
        reset = 1'b0;

        // Decoder sweep
        cycle(2'b10, 3'b000, 1'b1, 1'b1, 32'd6, 32'd3, 1'b0, 32'h0, 32'd0, "dec_rsub");
        cycle(2'b10, 3'b000, 1'b0, 1'b1, 32'd6, 32'd3, 1'b0, 32'h0, 32'd0, "dec_addi");
        cycle(2'b10, 3'b010, 1'b1, 1'b0, 32'd6, 32'd3, 1'b0, 32'h0, 32'd0, "dec_slt");
        cycle(2'b10, 3'b110, 1'b1, 1'b0, 32'd6, 32'd3, 1'b0, 32'h0, 32'd0, "dec_or");
        cycle(2'b10, 3'b111, 1'b1, 1'b0, 32'd6, 32'd3, 1'b0, 32'h0, 32'd0, "dec_and");
        cycle(2'b10, 3'b100, 1'b1, 1'b0, 32'd6, 32'd3, 1'b0, 32'h0, 32'd0, "dec_other");
        cycle(2'b00, 3'b111, 1'b1, 1'b1, 32'd6, 32'd3, 1'b0, 32'h0, 32'd0, "dec_op00");
        cycle(2'b01, 3'b111, 1'b1, 1'b1, 32'd6, 32'd3, 1'b0, 32'h0, 32'd0, "dec_op01");
        cycle(2'b11, 3'b111, 1'b1, 1'b1, 32'd6, 32'd3, 1'b0, 32'h0, 32'd0, "dec_op11");

        // ALU arithmetic and signed compare
        cycle(2'b00, 3'b000, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h0, 32'd0, "add_wrap");
        cycle(2'b01, 3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 1'b0, 32'h0, 32'd0, "sub_neg");
        cycle(2'b10, 3'b111, 1'b0, 1'b0, 32'h0F0F, 32'h00FF, 1'b0, 32'h0, 32'd0, "and");
        cycle(2'b10, 3'b110, 1'b0, 1'b0, 32'h0F0F, 32'h00FF, 1'b0, 32'h0, 32'd0, "or");
        cycle(2'b10, 3'b010, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h0, 32'd0, "slt_neg");
        cycle(2'b10, 3'b010, 1'b1, 1'b0, 32'd1, 32'hFFFFFFFF, 1'b0, 32'h0, 32'd0, "slt_pos");
        cycle(2'b10, 3'b010, 1'b1, 1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h0, 32'd0, "slt_eq");

        // Memory write/read, wrap and enable
        cycle(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h60, 32'hDEADBEEF, "wr_pre");
        cycle(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'h60, 32'd0, "rd_60");
        cycle(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'h63, 32'd0, "rd_63");
        cycle(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h100, 32'h1234, "wr_wrap");
        cycle(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'h0, 32'hFFFF, "we_off");
        cycle(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'h0, 32'd0, "rd_wrap");

        // Asynchronous reset between edges, and a write blocked by reset
        cycle(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hC, 32'hA5A5A5A5, "wr_w3");
        apply(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'hC, 32'd0, "rd_w3");
        reset = 1'b1;
        clear_model();
        apply(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'hC, 32'd0, "async_clr");
        cycle(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hC, 32'h1111, "rst_block");
        reset = 1'b0;
        apply(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'hC, 32'd0, "post_rst");
        cycle(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'h60, 32'd0, "post_rst60");

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            r   = $urandom();
            adr = (r & 32'hFFFFFF03) | (32'($urandom_range(0, 63)) << 2);
            cycle(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom(),
                  ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom(),
                  1'($urandom_range(0, 1)), adr, $urandom(), "random");
        end

        #5;
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain got %0d pending required 0", q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
